// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller.
package traffic_pkg;

  localparam int unsigned COUNT_W = 7;

  // Lamp encodings, {red, yellow, green}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    StNsGreen,
    StNsYellow,
    StAllRedA,
    StEwGreen,
    StEwYellow,
    StAllRedB
  } state_e;

  // Fixed cyclic phase order; unused encodings recover to NS green.
  function automatic state_e next_state(state_e s);
    case (s)
      StNsGreen:  return StNsYellow;
      StNsYellow: return StAllRedA;
      StAllRedA:  return StEwGreen;
      StEwGreen:  return StEwYellow;
      StEwYellow: return StAllRedB;
      default:    return StNsGreen;
    endcase
  endfunction

  // Lamp pattern for a state, packed as {ns, ew}.
  function automatic logic [5:0] lamps(state_e s);
    case (s)
      StNsGreen:  return {GREEN, RED};
      StNsYellow: return {YELLOW, RED};
      StEwGreen:  return {RED, GREEN};
      StEwYellow: return {RED, YELLOW};
      default:    return {RED, RED};
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: tick pulses for one cycle every CLK_DIV cycles.
module tick_gen #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;

  // Wrap at CLK_DIV-1 back to zero.
  always_comb begin
    pre_d = (pre_q == PreMax) ? '0 : pre_q + PreW'(1);
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Decoded from the register, so tick is 0 while pre_q sits at reset value 0.
  assign tick = (pre_q == PreMax);

endmodule

// File: rtl/traffic_controller.sv
// Two-way intersection phase sequencer with per-second countdown.
// Optional pedestrian shortening is built when TRAFFIC_PED_REQ_EN is defined.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50_000_000,
  parameter int unsigned GREEN_TIME   = 30,
  parameter int unsigned YELLOW_TIME  = 5,
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned PED_TIME     = 10
) (
  input  logic               clk,
  input  logic               rst,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic               ped_req,
`endif
  output logic [2:0]         ns_light,
  output logic [2:0]         ew_light,
  output logic [COUNT_W-1:0] count,
  output logic               tick
);

  // Durations must fit the two-digit display (1..69).
  if (CLK_DIV < 2 || GREEN_TIME < 1 || GREEN_TIME > 69 || YELLOW_TIME < 1 ||
      YELLOW_TIME > 69 || ALL_RED_TIME < 1 || ALL_RED_TIME > 69 || PED_TIME < 1 ||
      PED_TIME > 69) begin : g_param_check
    $error("traffic_controller: parameter out of range");
  end

  localparam logic [COUNT_W-1:0] GreenCnt  = COUNT_W'(GREEN_TIME);
  localparam logic [COUNT_W-1:0] YellowCnt = COUNT_W'(YELLOW_TIME);
  localparam logic [COUNT_W-1:0] AllRedCnt = COUNT_W'(ALL_RED_TIME);

  function automatic logic [COUNT_W-1:0] phase_len(state_e s);
    case (s)
      StNsGreen, StEwGreen:   return GreenCnt;
      StNsYellow, StEwYellow: return YellowCnt;
      default:                return AllRedCnt;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [2:0]         ns_q, ew_q;
  logic               phase_end;
  logic               is_green;

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign phase_end = tick && (count_q == COUNT_W'(1));
  assign is_green  = (state_q == StNsGreen) || (state_q == StEwGreen);

`ifdef TRAFFIC_PED_REQ_EN
  localparam logic [COUNT_W-1:0] PedCnt = COUNT_W'(PED_TIME);

  logic ped_pend_q, ped_pend_d;
  logic ped_shorten;

  // Shorten only while green with more than PED_TIME left; phase end takes precedence.
  assign ped_shorten = is_green && ped_pend_q && (count_q > PedCnt) && !phase_end;

  // Pending is consumed by any green cycle that is not the phase end; a new request wins.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (is_green && !phase_end) begin
      ped_pend_d = 1'b0;
    end
    if (ped_req) begin
      ped_pend_d = 1'b1;
    end
  end

  // Pedestrian pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pend_q <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
    end
  end
`else
  logic ped_shorten;
  assign ped_shorten = 1'b0;
`endif

  // Next phase and countdown: phase end, then pedestrian shortening, then plain decrement.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (phase_end) begin
      state_d = next_state(state_q);
      count_d = phase_len(state_d);
`ifdef TRAFFIC_PED_REQ_EN
    end else if (ped_shorten) begin
      count_d = PedCnt;
`endif
    end else if (tick) begin
      count_d = count_q - COUNT_W'(1);
    end
  end

  // Phase FSM with registered lamps and count; both directions update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StNsGreen;
      count_q <= GreenCnt;
      ns_q    <= GREEN;
      ew_q    <= RED;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      {ns_q, ew_q} <= lamps(state_d);
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign count    = count_q;

endmodule

// File: tb/tb_traffic_controller.sv
// Scoreboard bench for traffic_controller with a phase-table reference model.
module tb_traffic_controller;

  localparam int unsigned ClkDiv  = 4;
  localparam int unsigned GreenT  = 30;
  localparam int unsigned YellowT = 5;
  localparam int unsigned AllRedT = 2;
  localparam int unsigned PedT    = 10;
`ifdef TRAFFIC_PED_REQ_EN
  localparam bit PedEn = 1'b1;
`else
  localparam bit PedEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
`ifdef TRAFFIC_PED_REQ_EN
  logic       ped_req;
`endif
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [6:0] count;
  logic       tick;

  traffic_controller #(
    .CLK_DIV     (ClkDiv),
    .GREEN_TIME  (GreenT),
    .YELLOW_TIME (YellowT),
    .ALL_RED_TIME(AllRedT),
    .PED_TIME    (PedT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef TRAFFIC_PED_REQ_EN
    .ped_req (ped_req),
`endif
    .ns_light(ns_light),
    .ew_light(ew_light),
    .count   (count),
    .tick    (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic [6:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;

  // Reference model: phase index into a table, seconds left, cycle-in-second, pending request.
  int         dur[6]    = '{GreenT, YellowT, AllRedT, GreenT, YellowT, AllRedT};
  logic [2:0] ns_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int         m_ph, m_cnt, m_pre;
  bit         m_pend;

  task automatic model_step(input bit r, input bit p);
    bit   tk, last, grn, ev;
    int   old;
    exp_t e;
    if (r) begin
      m_ph = 0; m_cnt = dur[0]; m_pre = 0; m_pend = 1'b0;
      ev = 1'b1;
    end else begin
      tk    = (m_pre == ClkDiv - 1);
      m_pre = (m_pre + 1) % ClkDiv;
      old   = m_cnt;
      grn   = (m_ph == 0) || (m_ph == 3);
      last  = tk && (m_cnt == 1);
      if (last) begin
        m_ph  = (m_ph + 1) % 6;
        m_cnt = dur[m_ph];
      end else if (PedEn && grn && m_pend && m_cnt > PedT) begin
        m_cnt = PedT;
      end else if (tk) begin
        m_cnt = m_cnt - 1;
      end
      if (grn && !last) m_pend = 1'b0;
      if (p) m_pend = 1'b1;
      ev = tk || (m_cnt != old);
    end
    if (ev) begin
      e.ns  = ns_tab[m_ph];
      e.ew  = ew_tab[m_ph];
      e.cnt = 7'(m_cnt);
      exp_q.push_back(e);
    end
  endtask

  // Drive one cycle of inputs (2 time units after the edge) and predict the next edge.
  task automatic cycle(input bit r, input bit p);
    rst = r;
`ifdef TRAFFIC_PED_REQ_EN
    ped_req = p;
`endif
    model_step(r, p && PedEn);
    @(posedge clk);
    #2;
  endtask

  task automatic run_until(input int ph, input int cnt, input bit need_tick, input string name);
    int n = 0;
    while (!(m_ph == ph && m_cnt == cnt && (!need_tick || m_pre == ClkDiv - 1)) && n < 1000) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s: reached phase %0d count %0d, required phase %0d count %0d",
               name, m_ph, m_cnt, ph, cnt);
    end
  endtask

  // Monitor: on each edge that consumed a tick, a reset or changed the count, pop and compare.
  initial begin
    logic       s_tick, s_rst;
    logic [6:0] s_cnt;
    exp_t       e;
    forever begin
      @(negedge clk);
      s_tick = tick;
      s_rst  = rst;
      s_cnt  = count;
      @(posedge clk);
      #1;
      if (!done) begin
        checks++;
        if (!(count >= 7'd1 && count <= 7'd69 && $onehot(ns_light) && $onehot(ew_light) &&
              !(ns_light == 3'b001 && ew_light == 3'b001))) begin
          errors++;
          $display("FAIL invariant @%0t: ns=%b ew=%b count=%0d, required one-hot, one green max, 1..69",
                   $time, ns_light, ew_light, count);
        end
        if (s_tick || s_rst || count != s_cnt) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL update @%0t: ns=%b ew=%b count=%0d, required no change",
                     $time, ns_light, ew_light, count);
          end else begin
            e = exp_q.pop_front();
            if (ns_light !== e.ns || ew_light !== e.ew || count !== e.cnt) begin
              errors++;
              $display("FAIL update @%0t: ns=%b ew=%b count=%0d, required ns=%b ew=%b count=%0d",
                       $time, ns_light, ew_light, count, e.ns, e.ew, e.cnt);
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
`ifdef TRAFFIC_PED_REQ_EN
    ped_req = 1'b0;
`endif
    @(posedge clk);
    #2;
    // Reset held three cycles, then more than one full 74-second cycle.
    repeat (3) cycle(1'b1, 1'b0);
    repeat (320) cycle(1'b0, 1'b0);
    // Reset mid EW_YELLOW at count 3.
    run_until(4, 3, 1'b0, "reach_ew_yellow_3");
    cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);
`ifdef TRAFFIC_PED_REQ_EN
    run_until(0, 25, 1'b0, "reach_ns_green_25");
    cycle(1'b0, 1'b1);
    repeat (60) cycle(1'b0, 1'b0);
    run_until(0, 8, 1'b0, "reach_ns_green_8");
    cycle(1'b0, 1'b1);
    run_until(0, 1, 1'b1, "reach_ns_green_end");
    cycle(1'b0, 1'b1);
    repeat (120) cycle(1'b0, 1'b0);
`endif
    // Random run lengths, resets and pedestrian pulses.
    repeat (40) begin
      n = $urandom_range(1, 200);
      repeat (n) cycle(1'b0, $urandom_range(0, 99) < 2);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cycle(1'b1, 1'b0);
    end
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected updates left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
